// File: rtl/deg_pkg.sv
// Shared types and constants for the Q9.7 degree sweep datapath.
package deg_pkg;

    typedef logic [15:0] deg_q9_7_t;

    localparam int        DEG_FRAC = 7;
    localparam deg_q9_7_t DEG_FULL = 16'd46080;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } sweep_state_t;

endpackage

// File: rtl/deg_wrap_add.sv
// Combinational add/subtract of two Q9.7 angles modulo one full turn.
// The add path only needs a < 2*FULL, so it also reduces raw inputs when b = 0.
module deg_wrap_add
    import deg_pkg::*;
(
    input  deg_q9_7_t a,
    input  deg_q9_7_t b,
    input  logic      sub,
    output deg_q9_7_t y
);

    logic [16:0] sum;
    logic        sum_ge;
    logic        borrow;

    // Results always fit in 16 bits, so the correction can wrap mod 2^16.
    always_comb begin
        sum    = {1'b0, a} + {1'b0, b};
        sum_ge = (sum >= {1'b0, DEG_FULL});
        borrow = (a < b);
        if (sub) begin
            y = a - b + (borrow ? DEG_FULL : 16'd0);
        end else begin
            y = a + b - (sum_ge ? DEG_FULL : 16'd0);
        end
    end

endmodule

// File: rtl/deg_sweep_gen.sv
// Programmable Q9.7 angle-sweep sequencer with paced, registered outputs.
// Define DEG_SWEEP_DIR_EN to add the dir input for descending sweeps.
module deg_sweep_gen
    import deg_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int GAP_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      start_deg,
    input  logic [15:0]      step_deg,
    input  logic [CNT_W-1:0] n_points,
    input  logic [GAP_W-1:0] gap,
`ifdef DEG_SWEEP_DIR_EN
    input  logic             dir,
`endif
    output logic [15:0]      deg_out,
    output logic             valid_out,
    output logic             last,
    output logic             busy,
    output logic             done
);

    sweep_state_t     state_q, state_d;
    deg_q9_7_t        acc_q, acc_d;
    deg_q9_7_t        step_q, step_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [GAP_W-1:0] timer_q, timer_d;
    deg_q9_7_t        deg_q, deg_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             emit_next;

    deg_q9_7_t raw_in  [2];
    deg_q9_7_t red_out [2];
    deg_q9_7_t adv_a, adv_b, adv_y;
    logic      adv_sub;
    logic      in_idle;

    assign raw_in[0] = start_deg;
    assign raw_in[1] = step_deg;
    assign in_idle   = (state_q == IDLE);

    // Single conditional subtraction reduces each raw config angle into range.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_reduce
            deg_wrap_add u_reduce (
                .a   (raw_in[gi]),
                .b   (16'd0),
                .sub (1'b0),
                .y   (red_out[gi])
            );
        end
    endgenerate

`ifdef DEG_SWEEP_DIR_EN
    logic dir_q, dir_d;
    assign adv_sub = in_idle ? dir : dir_q;
`else
    assign adv_sub = 1'b0;
`endif

    // On start the first successor is computed straight from the reduced inputs.
    assign adv_a = in_idle ? red_out[0] : acc_q;
    assign adv_b = in_idle ? red_out[1] : step_q;

    deg_wrap_add u_advance (
        .a   (adv_a),
        .b   (adv_b),
        .sub (adv_sub),
        .y   (adv_y)
    );

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        step_d    = step_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        timer_d   = timer_q;
        deg_d     = deg_q;
        valid_d   = 1'b0;
        last_d    = 1'b0;
        emit_next = 1'b0;
`ifdef DEG_SWEEP_DIR_EN
        dir_d     = dir_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    step_d = red_out[1];
                    n_d    = n_points;
                    gap_d  = gap;
`ifdef DEG_SWEEP_DIR_EN
                    dir_d  = dir;
`endif
                    if (n_points == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = EMIT;
                        deg_d   = red_out[0];
                        acc_d   = adv_y;
                        cnt_d   = CNT_W'(1);
                        valid_d = 1'b1;
                        last_d  = (n_points == CNT_W'(1));
                    end
                end
            end
            EMIT: begin
                if (last_q) begin
                    state_d = DONE;
                end else if (gap_q == '0) begin
                    emit_next = 1'b1;
                end else begin
                    state_d = GAP;
                    timer_d = gap_q;
                end
            end
            GAP: begin
                if (timer_q == GAP_W'(1)) begin
                    emit_next = 1'b1;
                end else begin
                    timer_d = timer_q - GAP_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // cnt_q counts samples already emitted, so the next one is last when cnt_q+1 == n.
        if (emit_next) begin
            state_d = EMIT;
            deg_d   = acc_q;
            acc_d   = adv_y;
            cnt_d   = cnt_q + CNT_W'(1);
            valid_d = 1'b1;
            last_d  = ((cnt_q + CNT_W'(1)) == n_q);
        end

        if (abort) begin
            state_d = IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            step_q  <= '0;
            n_q     <= '0;
            cnt_q   <= '0;
            gap_q   <= '0;
            timer_q <= '0;
            deg_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            timer_q <= timer_d;
            deg_q   <= deg_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef DEG_SWEEP_DIR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
        end
    end
`endif

    assign deg_out   = deg_q;
    assign valid_out = valid_q;
    assign last      = last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_deg_sweep_gen.sv
// Self-checking bench for deg_sweep_gen: directed and random sweeps against a
// closed-form timing/value model. Honours DEG_SWEEP_DIR_EN when defined.
module tb_deg_sweep_gen;

    localparam int FULL = 46080;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [15:0] start_deg;
    logic [15:0] step_deg;
    logic [15:0] n_points;
    logic [15:0] gap;
    logic        dir;
    logic [15:0] deg_out;
    logic        valid_out;
    logic        last;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    deg_sweep_gen #(.CNT_W(16), .GAP_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .start_deg (start_deg),
        .step_deg  (step_deg),
        .n_points  (n_points),
        .gap       (gap),
`ifdef DEG_SWEEP_DIR_EN
        .dir       (dir),
`endif
        .deg_out   (deg_out),
        .valid_out (valid_out),
        .last      (last),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected angle of sample k, straight from the modular definition.
    function automatic int sample_val(input int s, input int st, input int k, input bit desc);
        longint rs, rst, v;
        rs  = s % FULL;
        rst = st % FULL;
        if (desc) v = rs - longint'(k) * rst;
        else      v = rs + longint'(k) * rst;
        v = ((v % FULL) + FULL) % FULL;
        return int'(v);
    endfunction

    // ab_c / inj_c: cycle (1-based after start) in which abort / a stray start is driven; 0 = none.
    task automatic run(input int s, input int st, input int n, input int g, input bit d,
                       input int ab_c, input int inj_c);
        int  period, dc, end_c, k, nsamp;
        bit  is_smp, aborted;
        period = g + 1;
        dc     = (n == 0) ? 1 : 1 + (n - 1) * period + 1;
        end_c  = (ab_c != 0) ? ab_c + 1 : dc + 1;
        nsamp  = 0;
        start_deg = 16'(s);
        step_deg  = 16'(st);
        n_points  = 16'(n);
        gap       = 16'(g);
        dir       = d;
        start     = 1'b1;
        for (int c = 1; c <= end_c; c++) begin
            @(negedge clk);
            start = 1'b0;
            abort = 1'b0;
            aborted = (ab_c != 0) && (c > ab_c);
            is_smp  = !aborted && (c <= dc) && (n > 0) && (((c - 1) % period) == 0)
                      && (((c - 1) / period) < n);
            k = (c - 1) / period;
            chk("valid_out", valid_out, is_smp);
            chk("busy", busy, !aborted && (c <= dc));
            chk("done", done, !aborted && (c == dc));
            chk("last", last, is_smp && (k == n - 1));
            if (is_smp) begin
                chk("deg_out", deg_out, sample_val(s, st, k, d));
            end
            if (valid_out) nsamp++;
            if (c == ab_c) abort = 1'b1;
            if (c == inj_c) begin
                start_deg = 16'($urandom);
                step_deg  = 16'($urandom);
                n_points  = 16'($urandom_range(1, 3));
                gap       = 16'($urandom_range(0, 2));
                start     = 1'b1;
            end
        end
        start = 1'b0;
        abort = 1'b0;
        if (ab_c == 0) chk("sample_count", nsamp, n);
        $display("run start=%0d step=%0d n=%0d gap=%0d dir=%0d abort_c=%0d inj_c=%0d samples=%0d",
                 s, st, n, g, d, ab_c, inj_c, nsamp);
    endtask

    initial begin
        bit rd;
        int rn, rg;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        start_deg = '0;
        step_deg  = '0;
        n_points  = '0;
        gap       = '0;
        dir       = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", valid_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_last", last, 0);
        chk("rst_deg", deg_out, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run(0, 11520, 5, 0, 1'b0, 0, 0);
        run(0, 11520, 5, 3, 1'b0, 0, 0);
        run(46000, 200, 3, 0, 1'b0, 0, 0);
        run(50000, 1000, 2, 1, 1'b0, 0, 0);
        run(65535, 65535, 4, 0, 1'b0, 0, 0);
        run(123, 456, 0, 2, 1'b0, 0, 0);
        run(1000, 3000, 1, 0, 1'b0, 0, 0);
        run(0, 11520, 8, 0, 1'b0, 2, 0);
        run(500, 7000, 8, 2, 1'b0, 5, 0);
        run(300, 9000, 4, 1, 1'b0, 0, 3);
        run(300, 9000, 3, 0, 1'b0, 0, 4);
`ifdef DEG_SWEEP_DIR_EN
        run(100, 200, 3, 0, 1'b1, 0, 0);
        run(0, 46079, 4, 1, 1'b1, 0, 0);
`endif

        for (int i = 0; i < 20; i++) begin
            rn = $urandom_range(0, 10);
            rg = $urandom_range(0, 4);
            rd = 1'b0;
`ifdef DEG_SWEEP_DIR_EN
            rd = 1'($urandom_range(0, 1));
`endif
            run(int'(16'($urandom)), int'(16'($urandom)), rn, rg, rd,
                ((i % 5) == 4) ? int'($urandom_range(1, 4)) : 0,
                ((i % 4) == 3) ? int'($urandom_range(1, 3)) : 0);
            if (($urandom_range(0, 1)) == 1) @(negedge clk);
        end

        // Asynchronous reset in the middle of a run.
        start_deg = 16'd1000;
        step_deg  = 16'd500;
        n_points  = 16'd8;
        gap       = 16'd0;
        dir       = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_valid", valid_out, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", valid_out, 0);
        chk("async_busy", busy, 0);
        chk("async_deg", deg_out, 0);
        chk("async_last", last, 0);
        chk("async_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_valid", valid_out, 0);
        chk("post_rst_busy", busy, 0);
        run(46000, 200, 3, 0, 1'b0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/deg_sweep_gen.md
Name: deg_sweep_gen

Overview:
- Programmable angle-sweep sequencer that produces a stream of unsigned Q9.7 degree samples.
- Each run emits n_points samples: start_deg, start_deg+step, ..., with every value wrapped modulo 360°.
- Sits directly upstream of deg2phase: deg_out/valid_out drive its deg_in/valid_in, which then feeds cordic_dds.
- Samples are paced by a programmable inter-sample gap; there is no backpressure, matching the downstream pipeline.

Parameters:
- CNT_W, 16, width of n_points and the internal sample counter.
- GAP_W, 16, width of gap and the internal pacing timer.

Ports:
- clk, in, 1, single clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle pulse; latches the config inputs and starts a run. Honoured only in IDLE.
- abort, in, 1, terminates the run immediately.
- start_deg, in, 16, first angle, Q9.7 unsigned.
- step_deg, in, 16, angle increment, Q9.7 unsigned.
- n_points, in, CNT_W, number of samples to emit.
- gap, in, GAP_W, idle cycles between consecutive samples; 0 means back-to-back.
- deg_out, out, 16, Q9.7 sample in range 0..46079.
- valid_out, out, 1, qualifies deg_out for exactly one cycle per sample.
- last, out, 1, high with the final valid_out of a run.
- busy, out, 1, high from the cycle after an accepted start until the return to IDLE.
- done, out, 1, one-cycle pulse marking normal completion.

Behaviour:
- Reset: all outputs are 0, the FSM is in IDLE, and the accumulator, counter and timer are 0.
- All outputs are registered.
- Full turn is FULL = 46080 (360·128).
- Config capture on start in IDLE:
  - start_deg and step_deg are each reduced by one conditional subtraction: if value ≥ FULL, subtract FULL. This is exact because 65535 < 2·FULL.
  - n_points and gap are latched; later input changes have no effect on the run.
- Wrap arithmetic: nxt = acc + step in 17 bits; if nxt ≥ FULL then nxt −= FULL. Result is always in 0..FULL−1.
- FSM states: IDLE, EMIT, GAP, DONE.
  - IDLE: start with n_points = 0 → DONE. start otherwise → EMIT. busy rises in the next cycle.
  - EMIT: valid_out = 1, deg_out = acc, then acc ← wrap(acc + step) and count++.
    - If count == n_points−1: last = 1 and go to DONE.
    - Else if gap = 0: stay in EMIT.
    - Else: timer ← gap and go to GAP.
  - GAP: valid_out = 0; timer decrements; go to EMIT when timer reaches 1.
  - DONE: done = 1 for one cycle, busy = 0 in the following cycle, return to IDLE.
- Timing:
  - First valid_out appears 1 cycle after the accepted start.
  - Sample period is gap+1 cycles.
  - done appears 1 cycle after the last sample.
  - For n_points = 0, done appears 1 cycle after start.
- start while not IDLE: ignored, with no effect on the run.
- abort in any non-IDLE state: next cycle IDLE, valid_out/last/busy = 0, no done pulse. abort has priority over start in the same cycle.
- Async reset mid-run: outputs drop to 0 immediately; there is no partial-run recovery.
- Counter: CNT_W bits, so a run never exceeds 2^CNT_W−1 samples.

Optional Feature:
- Macro: DEG_SWEEP_DIR_EN.
- Defined:
  - Adds input port dir (1 bit), latched at start.
  - dir = 1 makes the sweep descend: nxt = acc − step; if negative, add FULL.
  - dir = 0 behaves as the ascending sweep above.
- Undefined: the dir port is absent and the sweep is ascending only.

Decomposition:
- Shared package deg_pkg:
  - typedef deg_q9_7_t = logic [15:0].
  - DEG_FRAC = 7.
  - DEG_FULL = 16'd46080.
  - enum sweep_state_t {IDLE, EMIT, GAP, DONE}.
- One sub-module, deg_wrap_add: combinational modular add/subtract of two deg_q9_7_t values modulo DEG_FULL. It is reused for the input reduction and for DIR support.

Test Plan:
- Basic run: start_deg=0, step=11520, n=5, gap=0 → deg_out 0, 11520, 23040, 34560, 0 on 5 consecutive cycles starting at t+1; last on the 5th sample; done at t+6.
- Pacing: the same run with gap=3 → valid_out at t+1, t+5, t+9, t+13, t+17; busy stays high throughout; done at t+18.
- Wrap and reduction: start_deg=46000, step=200, n=3 → samples 46000, 120, 320. start_deg=50000 → first sample 3920.
- Empty run: n_points=0 → no valid_out, done pulse at t+1. A start pulse during a run is ignored and the sample count is unchanged.
- Abort and reset: abort after the 2nd of 8 samples → no further valid_out, no done, busy=0 one cycle later. rst_n low mid-run → all outputs 0 asynchronously.
- DIR (macro defined): start_deg=100, step=200, dir=1, n=3 → samples 100, 45980, 45780.
